fpu_issue: RTL and testbench

FPU_ISSUE -- requirements
Module: fpu_issue

---
 rtl/fpu_issue.sv | 110 +++++++++++
 tb/tb_fpu_issue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue.sv
// FPU issue/writeback sequencer: accepts one op at a time, times its latency,
// then holds the result for writeback until consumed or flushed.
package fpu_pkg;
  typedef enum logic [3:0] {
    FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SQRT, FPU_COND, FPU_MFC, FPU_MTC,
    FPU_MOV, FPU_ABS, FPU_NEG, FPU_CVT, FPU_INVALID
  } fpuOp_t;
endpackage

module fpu_issue
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD   = 3,
  parameter int unsigned LAT_DIV   = 9,
  parameter int unsigned LAT_SHORT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  fpuOp_t     in_op,
  input  logic [4:0] in_fd,
  input  logic       in_fd_we,
  output logic       ex_start,
  output fpuOp_t     ex_op,
  output logic       ex_hold,
  output logic       ex_flush,
  output logic       wb_valid,
  input  logic       wb_ready,
  output logic [4:0] wb_fd,
  output logic       wb_we,
  output logic       stall_req,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t     state;
  logic [3:0] cnt;
  fpuOp_t     op_q;
  logic [4:0] fd_q;
  logic       fd_we_q;
  logic [3:0] lat;
  logic       accept;

  always_comb begin
    lat = 4'd1;
    case (in_op)
      FPU_ADD, FPU_SUB, FPU_MUL: lat = 4'(LAT_ADD);
      FPU_DIV, FPU_SQRT:         lat = 4'(LAT_DIV);
      FPU_COND, FPU_MFC:         lat = 4'(LAT_SHORT);
      default:                   lat = 4'd1;
    endcase
  end

  // rst_n is folded in so every handshake output reads 0 while reset is held
  assign in_ready  = rst_n && (state == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign ex_start  = accept;
  assign ex_op     = accept ? in_op : op_q;
  assign ex_flush  = flush;
  assign wb_valid  = (state == HOLD);
  assign ex_hold   = (state == HOLD) && !wb_ready;
  assign wb_fd     = wb_valid ? fd_q : '0;
  assign wb_we     = wb_valid && fd_we_q;
  assign busy      = (state != IDLE);
  assign stall_req = rst_n && in_valid && !in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= fpuOp_t'(4'd0);
      fd_q    <= '0;
      fd_we_q <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= fpuOp_t'(4'd0);
      fd_q    <= '0;
      fd_we_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= in_op;
            fd_q    <= in_fd;
            fd_we_q <= in_fd_we;
            if (lat <= 4'd1) begin
              state <= HOLD;
            end else begin
              state <= EXEC;
              cnt   <= lat - 4'd2;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) state <= HOLD;
          else             cnt   <= cnt - 4'd1;
        end
        HOLD: begin
          if (wb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue: stimulus pushes expected writebacks into a
// queue, an independent monitor pops and compares them on each retirement.
module tb_fpu_issue;
  import fpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  fpuOp_t     in_op = FPU_ADD;
  logic [4:0] in_fd = '0;
  logic       in_fd_we = 1'b0;
  logic       ex_start;
  fpuOp_t     ex_op;
  logic       ex_hold;
  logic       ex_flush;
  logic       wb_valid;
  logic       wb_ready = 1'b0;
  logic [4:0] wb_fd;
  logic       wb_we;
  logic       stall_req;
  logic       busy;

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [4:0]  fd;
    logic        we;
    int unsigned when;
  } exp_t;
  exp_t sb[$];

  fpu_issue #(.LAT_ADD(3), .LAT_DIV(9), .LAT_SHORT(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_fd(in_fd), .in_fd_we(in_fd_we),
    .ex_start(ex_start), .ex_op(ex_op), .ex_hold(ex_hold), .ex_flush(ex_flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_fd(wb_fd), .wb_we(wb_we),
    .stall_req(stall_req), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] fd, input logic we, input int unsigned when);
    exp_t e;
    e.fd = fd; e.we = we; e.when = when;
    sb.push_back(e);
  endtask

  // Monitor: compare every retirement against the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 32'(wb_fd), 32'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_fd", 32'(wb_fd), 32'(e.fd));
          chk("wb_we", 32'(wb_we), 32'(e.we));
          chk("retire_cycle", cyc, e.when);
        end
      end else if (!wb_valid) begin
        chk("wb_idle_zero", {26'd0, wb_fd, wb_we}, 32'd0);
      end
    end
  end

  task automatic run_op(input fpuOp_t op, input logic [4:0] fd, input logic we,
                        input int unsigned lat, input int unsigned stl, input logic hold);
    int unsigned t0;
    int unsigned last;
    last = lat + stl;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_fd = fd; in_fd_we = we; wb_ready = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk("accept_ex_start", 32'(ex_start), 32'd1);
    chk("accept_ex_op", 32'(ex_op), 32'(op));
    push(fd, we, t0 + last);
    for (int unsigned k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      in_valid = hold && (k <= last);
      wb_ready = !(k >= lat && k < last);
      @(negedge clk);
      chk("wb_valid", 32'(wb_valid), 32'(k >= lat && k <= last));
      chk("ex_hold", 32'(ex_hold), 32'(k >= lat && k < last));
      chk("in_ready", 32'(in_ready), 32'(k == last + 1));
      chk("busy", 32'(busy), 32'(k <= last));
      chk("stall_req", 32'(stall_req), 32'(hold && k <= last));
      chk("ex_start_busy", 32'(ex_start), 32'd0);
      if (k <= last) chk("ex_op_held", 32'(ex_op), 32'(op));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    in_valid = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_ex_start", 32'(ex_start), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op(FPU_ADD,     5'd5,  1'b1, 3, 0, 1'b0);
    run_op(FPU_DIV,     5'd7,  1'b1, 9, 2, 1'b0);
    run_op(FPU_COND,    5'd3,  1'b0, 2, 0, 1'b0);
    run_op(FPU_MUL,     5'd9,  1'b1, 3, 1, 1'b1);
    run_op(FPU_INVALID, 5'd31, 1'b1, 1, 0, 1'b0);
    run_op(FPU_SQRT,    5'd12, 1'b1, 9, 0, 1'b0);
    run_op(FPU_SUB,     5'd0,  1'b0, 3, 3, 1'b1);
    run_op(FPU_ABS,     5'd17, 1'b1, 1, 2, 1'b0);

    // Back-to-back MOVs: second is offered in the cycle after the first retires
    begin
      int unsigned t0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = FPU_MOV; in_fd = 5'd1; in_fd_we = 1'b1; wb_ready = 1'b1;
      @(negedge clk);
      t0 = cyc;
      chk("mov1_ex_start", 32'(ex_start), 32'd1);
      push(5'd1, 1'b1, t0 + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mov1_wb_valid", 32'(wb_valid), 32'd1);
      chk("mov1_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = FPU_MOV; in_fd = 5'd2; in_fd_we = 1'b0;
      @(negedge clk);
      chk("mov2_in_ready", 32'(in_ready), 32'd1);
      chk("mov2_ex_start", 32'(ex_start), 32'd1);
      push(5'd2, 1'b0, t0 + 3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mov2_wb_valid", 32'(wb_valid), 32'd1);
      @(posedge clk); #1;
    end

    // SQRT killed by flush five cycles after accept
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = FPU_SQRT; in_fd = 5'd4; in_fd_we = 1'b1;
    @(negedge clk);
    chk("sqrt_ex_start", 32'(ex_start), 32'd1);
    for (int unsigned k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      in_valid = (k == 5); flush = (k == 5);
      @(negedge clk);
      chk("fl_ex_flush", 32'(ex_flush), 32'(k == 5));
      chk("fl_wb_valid", 32'(wb_valid), 32'd0);
      chk("fl_busy", 32'(busy), 32'd1);
      chk("fl_ex_start", 32'(ex_start), 32'd0);
      chk("fl_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fl_after_busy", 32'(busy), 32'd0);
    chk("fl_after_in_ready", 32'(in_ready), 32'd1);
    chk("fl_after_wb_valid", 32'(wb_valid), 32'd0);

    // Flush coinciding with wb_ready in HOLD still retires the op
    begin
      int unsigned t0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = FPU_ADD; in_fd = 5'd6; in_fd_we = 1'b1; wb_ready = 1'b1;
      @(negedge clk);
      t0 = cyc;
      push(5'd6, 1'b1, t0 + 3);
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; flush = 1'b1;
      @(negedge clk);
      chk("flret_wb_valid", 32'(wb_valid), 32'd1);
      chk("flret_ex_flush", 32'(ex_flush), 32'd1);
      @(posedge clk); #1; flush = 1'b0;
      @(negedge clk);
      chk("flret_busy", 32'(busy), 32'd0);
      chk("flret_in_ready", 32'(in_ready), 32'd1);
    end

    // Asynchronous reset mid-EXEC of MUL
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = FPU_MUL; in_fd = 5'd8; in_fd_we = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mul_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    chk("arst_ex_start", 32'(ex_start), 32'd0);
    chk("arst_stall", 32'(stall_req), 32'd0);
    chk("arst_ex_hold", 32'(ex_hold), 32'd0);
    chk("arst_wb_fd_we", {26'd0, wb_fd, wb_we}, 32'd0);
    chk("arst_ex_op", 32'(ex_op), 32'd0);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("arst_after_wb_valid", 32'(wb_valid), 32'd0);
      chk("arst_after_in_ready", 32'(in_ready), 32'd1);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
